// File: rtl/mcpu_alu_arb.sv
// Two-requester round-robin front end for a single shared mcpu_alu: operand register -> ALU -> response register.
// Optional MCPU_ALU_ARB_INVALID_CNT_EN adds a saturating invalid-op response counter (invalid_cnt).
module mcpu_alu_arb #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clkrst_core_clk,
  input  logic                 clkrst_core_rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [63:0]          req_op1,
  input  logic [63:0]          req_op2,
  input  logic [7:0]           req_opcode,
  input  logic [5:0]           req_compare_type,
  input  logic [3:0]           req_shift_type,
  input  logic [9:0]           req_shift_amount,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  output logic [3:0]           alu_opcode,
  output logic [2:0]           alu_compare_type,
  output logic [1:0]           alu_shift_type,
  output logic [4:0]           alu_shift_amount,
  input  logic [31:0]          alu_result,
  input  logic                 alu_invalid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [31:0]          rsp_result,
  output logic                 rsp_invalid
`ifdef MCPU_ALU_ARB_INVALID_CNT_EN
  ,
  output logic [CNT_W-1:0]     invalid_cnt
`endif
);

  localparam int NUM_LANES = 2;

  // Per-lane views of the packed request buses; index i is requester i.
  logic [NUM_LANES-1:0][31:0]      op1_l, op2_l;
  logic [NUM_LANES-1:0][3:0]       opc_l;
  logic [NUM_LANES-1:0][2:0]       ct_l;
  logic [NUM_LANES-1:0][1:0]       st_l;
  logic [NUM_LANES-1:0][4:0]       sa_l;
  logic [NUM_LANES-1:0][TAG_W-1:0] tag_l;

  assign op1_l = req_op1;
  assign op2_l = req_op2;
  assign opc_l = req_opcode;
  assign ct_l  = req_compare_type;
  assign st_l  = req_shift_type;
  assign sa_l  = req_shift_amount;
  assign tag_l = req_tag;

  logic             op_valid, op_id, last_grant, gnt, accept;
  logic [TAG_W-1:0] op_tag;
  logic             rsp_free, op_adv, op_free;

  assign rsp_free = ~rsp_valid | rsp_ready;
  assign op_adv   = op_valid & rsp_free;
  assign op_free  = ~op_valid | op_adv;

  // Grant looks only at the valid bits, so ready never depends on the loser's fields.
  always_comb begin
    gnt = req_valid[1];
    if (req_valid == 2'b11) gnt = ~last_grant;
    req_ready      = '0;
    req_ready[gnt] = op_free & ~clkrst_core_rst;
  end

  assign accept = req_valid[gnt] & req_ready[gnt];

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      op_valid         <= 1'b0;
      op_id            <= 1'b0;
      op_tag           <= '0;
      last_grant       <= 1'b1;
      alu_op1          <= '0;
      alu_op2          <= '0;
      alu_opcode       <= '0;
      alu_compare_type <= '0;
      alu_shift_type   <= '0;
      alu_shift_amount <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= 1'b0;
      rsp_tag          <= '0;
      rsp_result       <= '0;
      rsp_invalid      <= 1'b0;
    end else begin
      if (accept) begin
        op_valid         <= 1'b1;
        op_id            <= gnt;
        op_tag           <= tag_l[gnt];
        last_grant       <= gnt;
        alu_op1          <= op1_l[gnt];
        alu_op2          <= op2_l[gnt];
        alu_opcode       <= opc_l[gnt];
        alu_compare_type <= ct_l[gnt];
        alu_shift_type   <= st_l[gnt];
        alu_shift_amount <= sa_l[gnt];
      end else if (op_adv) begin
        op_valid <= 1'b0;
      end
      if (op_adv) begin
        rsp_valid   <= 1'b1;
        rsp_id      <= op_id;
        rsp_tag     <= op_tag;
        rsp_result  <= alu_result;
        rsp_invalid <= alu_invalid;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MCPU_ALU_ARB_INVALID_CNT_EN
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst)
      invalid_cnt <= '0;
    else if (rsp_valid && rsp_ready && rsp_invalid && !(&invalid_cnt))
      invalid_cnt <= invalid_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mcpu_alu_arb.sv
// Directed bench for mcpu_alu_arb with a small stand-in ALU (add/sub/and/or/xor, others invalid).
module tb_mcpu_alu_arb;
  localparam int TAG_W = 4;
`ifdef MCPU_ALU_ARB_INVALID_CNT_EN
  localparam int CNT_W = 2;
  logic [CNT_W-1:0] invalid_cnt;
`else
  localparam int CNT_W = 16;
`endif

  logic clk, rst;
  logic [1:0] req_valid, req_ready;
  logic [1:0][31:0] req_op1, req_op2;
  logic [1:0][3:0] req_opcode;
  logic [1:0][2:0] req_compare_type;
  logic [1:0][1:0] req_shift_type;
  logic [1:0][4:0] req_shift_amount;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [31:0] alu_op1, alu_op2, alu_result, rsp_result;
  logic [3:0] alu_opcode;
  logic [2:0] alu_compare_type;
  logic [1:0] alu_shift_type;
  logic [4:0] alu_shift_amount;
  logic alu_invalid, rsp_valid, rsp_ready, rsp_id, rsp_invalid;
  logic [TAG_W-1:0] rsp_tag;

  mcpu_alu_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
    .req_compare_type(req_compare_type), .req_shift_type(req_shift_type),
    .req_shift_amount(req_shift_amount), .req_tag(req_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_compare_type(alu_compare_type), .alu_shift_type(alu_shift_type),
    .alu_shift_amount(alu_shift_amount), .alu_result(alu_result),
    .alu_invalid(alu_invalid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_result(rsp_result),
    .rsp_invalid(rsp_invalid)
`ifdef MCPU_ALU_ARB_INVALID_CNT_EN
    , .invalid_cnt(invalid_cnt)
`endif
  );

  always_comb begin
    alu_invalid = 1'b0;
    case (alu_opcode)
      4'h0: alu_result = alu_op1 + alu_op2;
      4'h1: alu_result = alu_op1 - alu_op2;
      4'h2: alu_result = alu_op1 & alu_op2;
      4'h3: alu_result = alu_op1 | alu_op2;
      4'h4: alu_result = alu_op1 ^ alu_op2;
      default: begin alu_result = 32'h0; alu_invalid = 1'b1; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  opc;
    logic [31:0] a, b;
    logic [2:0]  ct;
    logic [1:0]  st;
    logic [4:0]  sa;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        inv;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b0, 4'h0, 32'd5,          32'd7,          3'd0, 2'd0, 5'd0,  4'h3, 32'd12,         1'b0};
    vt[1] = '{1'b1, 4'h1, 32'd3,          32'd5,          3'd2, 2'd1, 5'd17, 4'h9, 32'hFFFF_FFFE,  1'b0};
    vt[2] = '{1'b0, 4'h2, 32'hF0F0_00FF,  32'h0FF0_0F0F,  3'd5, 2'd2, 5'd31, 4'hF, 32'h00F0_000F,  1'b0};
    vt[3] = '{1'b1, 4'h3, 32'h1200_0034,  32'h0056_7800,  3'd7, 2'd3, 5'd1,  4'h0, 32'h1256_7834,  1'b0};
    vt[4] = '{1'b1, 4'h8, 32'h0000_1234,  32'h0000_5678,  3'd0, 2'd0, 5'd0,  4'hA, 32'h0,          1'b1};
    vt[5] = '{1'b0, 4'h4, 32'hFFFF_0000,  32'h0F0F_0F0F,  3'd1, 2'd0, 5'd4,  4'h6, 32'hF0F0_0F0F,  1'b0};

    rst = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
    req_op1 = '0; req_op2 = '0; req_opcode = '0; req_compare_type = '0;
    req_shift_type = '0; req_shift_amount = '0; req_tag = '0;
    tick(); tick();
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_alu_op1", alu_op1, 32'h0);
    chk("reset_rsp_tag", rsp_tag, 4'h0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    rst = 1'b0; req_valid = 2'b00;
    tick();

    // Single ops, other lane carries garbage so the mux is exercised.
    for (int i = 0; i < 6; i++) begin
      req_op1 = {2{32'hDEAD_BEEF}}; req_op2 = {2{32'hCAFE_F00D}};
      req_opcode = 8'hFF; req_compare_type = 6'h3F; req_shift_type = 4'hF;
      req_shift_amount = 10'h3FF; req_tag = 8'hCC;
      req_op1[vt[i].r] = vt[i].a; req_op2[vt[i].r] = vt[i].b;
      req_opcode[vt[i].r] = vt[i].opc; req_compare_type[vt[i].r] = vt[i].ct;
      req_shift_type[vt[i].r] = vt[i].st; req_shift_amount[vt[i].r] = vt[i].sa;
      req_tag[vt[i].r] = vt[i].tag;
      req_valid = 2'b00; req_valid[vt[i].r] = 1'b1;
      #1;
      chk("vec_req_ready", req_ready, req_valid);
      tick();
      req_valid = 2'b00;
      chk("vec_latency_rsp_valid", rsp_valid, 1'b0);
      chk("vec_alu_op1", alu_op1, vt[i].a);
      chk("vec_alu_op2", alu_op2, vt[i].b);
      chk("vec_alu_opcode", alu_opcode, vt[i].opc);
      chk("vec_alu_fields", {alu_compare_type, alu_shift_type, alu_shift_amount},
          {vt[i].ct, vt[i].st, vt[i].sa});
      tick();
      chk("vec_rsp_valid", rsp_valid, 1'b1);
      chk("vec_rsp_id", rsp_id, vt[i].r);
      chk("vec_rsp_tag", rsp_tag, vt[i].tag);
      chk("vec_rsp_result", rsp_result, vt[i].res);
      chk("vec_rsp_invalid", rsp_invalid, vt[i].inv);
      tick();
    end
`ifdef MCPU_ALU_ARB_INVALID_CNT_EN
    chk("invalid_cnt_one", invalid_cnt, 2'd1);
`endif

    // Fairness after reset: both valid, grants alternate starting with r0.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    req_opcode = 8'h00; req_op1[0] = 32'd100; req_op1[1] = 32'd200;
    req_op2 = {32'd1, 32'd1}; req_tag[0] = 4'h1; req_tag[1] = 4'h2;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 2'b11 : 2'b00;
      #1;
      if (k < 6) chk("fair_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k < 2) chk("fair_idle_rsp", rsp_valid, 1'b0);
      else begin
        chk("fair_rsp_valid", rsp_valid, 1'b1);
        chk("fair_rsp_id", rsp_id, (k - 2) % 2);
        chk("fair_rsp_tag", rsp_tag, ((k - 2) % 2 == 0) ? 4'h1 : 4'h2);
        chk("fair_rsp_result", rsp_result, ((k - 2) % 2 == 0) ? 32'd101 : 32'd201);
      end
      tick();
    end

    // Backpressure: r1 streams 3, only 2 fit.
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req_op1[1] = 32'((s + 1) * 10); req_tag[1] = 4'(s + 1);
      req_valid = 2'b10;
      #1;
      chk("bp_req_ready", req_ready, (s < 2) ? 2'b10 : 2'b00);
      tick();
    end
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    chk("bp_rsp_tag", rsp_tag, 4'h1);
    chk("bp_rsp_result", rsp_result, 32'd11);
    tick();
    chk("bp_hold_tag", rsp_tag, 4'h1);
    chk("bp_hold_result", rsp_result, 32'd11);
    chk("bp_hold_ready", req_ready, 2'b00);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("bp_drain2_tag", rsp_tag, 4'h2);
    chk("bp_drain2_result", rsp_result, 32'd21);
    tick();
    chk("bp_drain3_tag", rsp_tag, 4'h3);
    chk("bp_drain3_result", rsp_result, 32'd31);
    tick();
    chk("bp_drained", rsp_valid, 1'b0);

    // Five back-to-back invalid ops from r1.
    req_opcode[1] = 4'h8; req_tag[1] = 4'h7; req_valid = 2'b10;
    for (int s = 0; s < 5; s++) tick();
    chk("inv_rsp_valid", rsp_valid, 1'b1);
    chk("inv_rsp_invalid", rsp_invalid, 1'b1);
    chk("inv_rsp_result", rsp_result, 32'h0);
    req_valid = 2'b00;
    tick(); tick(); tick();
`ifdef MCPU_ALU_ARB_INVALID_CNT_EN
    chk("invalid_cnt_sat", invalid_cnt, 2'd3);
`endif

    // Reset with two ops in flight.
    rsp_ready = 1'b0; req_opcode = 8'h00; req_valid = 2'b01;
    tick(); tick();
    chk("mid_full_rsp", rsp_valid, 1'b1);
    req_valid = 2'b11; rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 2'b00);
    tick();
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    tick();
    chk("mid_no_stale1", rsp_valid, 1'b0);
    tick();
    chk("mid_no_stale2", rsp_valid, 1'b0);
    req_valid = 2'b11;
    #1;
    chk("mid_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("mid_rsp_valid", rsp_valid, 1'b1);
    chk("mid_rsp_id", rsp_id, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mcpu_alu_arb.md
Name: mcpu_alu_arb

Overview:
Shares one mcpu_alu instance between two requesters, for example the two issue lanes, or a lane plus the branch/compare unit.
- Round-robin arbitration with valid/ready handshakes on the request side.
- Two-stage pipeline: operand register, then the combinational ALU, then a response register.
- Single response channel with ready backpressure; each response carries the requester ID and tag.

Parameters:
TAG_W, 4, width of the opaque per-request tag returned with the result
CNT_W, 16, width of the invalid-op counter (optional feature only)

Ports:
clkrst_core_clk  in  1  core clock; all state updates on its rising edge
clkrst_core_rst  in  1  synchronous, active-high reset
req_valid  in  2  request valid; bit i is requester i
req_ready  out  2  request accepted this cycle when req_valid[i] and req_ready[i] are both high
req_op1  in  64  op1; requester i uses bits [32i+31:32i]
req_op2  in  64  op2; same packing as req_op1
req_opcode  in  8  4 bits per requester
req_compare_type  in  6  3 bits per requester
req_shift_type  in  4  2 bits per requester
req_shift_amount  in  10  5 bits per requester
req_tag  in  2*TAG_W  TAG_W bits per requester
alu_op1, alu_op2  out  32 each  driven from the operand register
alu_opcode  out  4  driven from the operand register
alu_compare_type  out  3  driven from the operand register
alu_shift_type  out  2  driven from the operand register
alu_shift_amount  out  5  driven from the operand register
alu_result  in  32  combinational ALU result
alu_invalid  in  1  combinational ALU invalid flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high
rsp_id  out  1  requester that issued this response
rsp_tag  out  TAG_W  tag of that request
rsp_result  out  32  captured alu_result
rsp_invalid  out  1  captured alu_invalid
invalid_cnt  out  CNT_W  invalid-op counter (present only with the optional feature)

Behaviour:
- Reset (synchronous, wins over every other update):
  - op_valid=0, rsp_valid=0, last_grant=1, so requester 0 wins first.
  - rsp_id, rsp_tag, rsp_result, rsp_invalid = 0; alu_* outputs = 0.
  - req_ready=0 while reset is asserted.
- Pipeline control:
  - rsp_free = !rsp_valid | rsp_ready
  - op_adv = op_valid & rsp_free
  - op_free = !op_valid | op_adv
- Arbitration (combinational):
  - If only one requester is valid, grant it.
  - If both are valid, grant !last_grant.
  - req_ready[g] = op_free for the granted requester g; the other bit is 0.
  - req_ready never depends on the non-granted requester's fields.
- On accept:
  - Load requester g's fields and tag into the operand register; op_valid=1.
  - last_grant=g.
  - last_grant changes only on an accept.
- On op_adv:
  - Load alu_result and alu_invalid into the response register, with id/tag from the operand register; rsp_valid=1.
  - If there is no accept the same cycle, op_valid=0.
- On a response handshake with no op_adv: rsp_valid=0.
- Simultaneous events:
  - Accept, op_adv and response handshake can all occur in one cycle.
  - Throughput is 1 op/clk while rsp_ready stays high.
- Latency: a request accepted at edge N gives rsp_valid high after edge N+1, visible in cycle N+2.
- Backpressure, rsp_ready low:
  - Response register and operand register both hold their values.
  - At most 2 ops are in flight; req_ready=0 once both stages are full.
- Ordering: responses are returned strictly in accept order, with no reordering and no drops.
- Invalid opcodes:
  - Not trapped; they complete normally with rsp_invalid=1 and rsp_result as the ALU drives it (0).
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Reset mid-operation: in-flight ops are discarded and no response is produced for them.
- Stability: outputs hold their values while rsp_valid is high and rsp_ready is low.

Optional Feature:
MCPU_ALU_ARB_INVALID_CNT_EN
- Defined:
  - invalid_cnt port exists.
  - Increments by 1 on each response handshake with rsp_invalid=1.
  - Saturates at all-ones; reset value 0.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Single request, rsp_ready=1: r0 sends opcode 0000, op1=5, op2=7, shift 0, tag=3.
  - Response in cycle N+2: rsp_result=12, rsp_id=0, rsp_tag=3, rsp_invalid=0.
- Both requesters valid for 6 cycles after reset, rsp_ready=1:
  - Grants go 0,1,0,1,0,1.
  - rsp_id sequence matches the grants, one response per cycle.
- Backpressure: rsp_ready=0 while r1 streams 3 requests.
  - Only 2 are accepted; req_ready[1]=0 on the third.
  - Response 1 is held stable.
  - After rsp_ready=1, 3 responses drain in order with tags intact.
- Invalid opcode 1000 from r1:
  - rsp_invalid=1, rsp_result=0.
  - With MCPU_ALU_ARB_INVALID_CNT_EN, invalid_cnt goes 0->1.
  - Saturation check with CNT_W=2: 5 invalids leave invalid_cnt=3.
- Reset asserted while 2 ops are in flight:
  - rsp_valid=0 the following cycle and no stale response appears.
  - The next grant with both requesters valid goes to r0.
